// File: rtl/pe_result_drain.sv
// Result drain: buffers whole 2x2 result matrices in a circular FIFO and
// serializes each one as four elements (c11, c12, c21, c22) on a ready/valid port.
module pe_result_drain #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_val,
   input  logic [2*WIDTH:0]          c11,
   input  logic [2*WIDTH:0]          c12,
   input  logic [2*WIDTH:0]          c21,
   input  logic [2*WIDTH:0]          c22,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*WIDTH:0]          out_data,
   output logic [1:0]                out_idx,
   output logic                      out_last,
   output logic                      afull,
   output logic                      ovf,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned EW = 2 * WIDTH + 1;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] Full = CW'(DEPTH);

   typedef enum logic {StEmpty, StSend} state_t;

   state_t            state_q, state_d;
   logic [4*EW-1:0]   mem [DEPTH];
   logic [4*EW-1:0]   head;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [1:0]        elem_q, elem_d;
   logic              ovf_q, ovf_d;
   logic              beat, pop, wr;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      elem_d   = elem_q;
      ovf_d    = ovf_q;

      beat = (state_q == StSend) && out_ready;
      pop  = beat && (elem_q == 2'd3);
      // A full FIFO still accepts when the head matrix leaves this same cycle.
      wr   = in_val && ((count_q != Full) || pop);

      if (beat) begin
         elem_d = elem_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (wr) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (wr && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !wr) begin
         count_d = count_q - CW'(1);
      end

      if (in_val && !wr) begin
         ovf_d = 1'b1;
      end

      state_d = (count_d != '0) ? StSend : StEmpty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StEmpty;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         elem_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         elem_q   <= elem_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (!rst && wr) begin
         mem[wr_ptr_q] <= {c22, c21, c12, c11};
      end
   end

   always_comb begin
      head     = mem[rd_ptr_q];
      out_data = head[EW-1:0];
      unique case (elem_q)
         2'd0: out_data = head[EW-1:0];
         2'd1: out_data = head[2*EW-1:EW];
         2'd2: out_data = head[3*EW-1:2*EW];
         2'd3: out_data = head[4*EW-1:3*EW];
      endcase
   end

   assign out_valid = (state_q == StSend);
   assign out_idx   = elem_q;
   assign out_last  = (elem_q == 2'd3);
   assign afull     = (count_q >= Full - CW'(1));
   assign ovf       = ovf_q;
   assign count     = count_q;

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: a reference model tracks count/elem/ovf and a
// scoreboard queue holds every element expected on the output port, in order.
module tb_pe_result_drain;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned EW    = 2 * WIDTH + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_val;
   logic [EW-1:0] c11, c12, c21, c22;
   logic          out_valid;
   logic          out_ready;
   logic [EW-1:0] out_data;
   logic [1:0]    out_idx;
   logic          out_last;
   logic          afull;
   logic          ovf;
   logic [2:0]    count;

   typedef struct packed {
      logic [1:0]    idx;
      logic [EW-1:0] data;
   } el_t;

   el_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  mcount = 0;
   int  melem = 0;
   int  maxcount = 0;
   bit  movf = 1'b0;

   pe_result_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_val    (in_val),
      .c11       (c11),
      .c12       (c12),
      .c21       (c21),
      .c22       (c22),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .afull     (afull),
      .ovf       (ovf),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [EW-1:0] a, input logic [EW-1:0] b,
                       input logic [EW-1:0] c, input logic [EW-1:0] d);
      in_val = 1'b1;
      c11 = a; c12 = b; c21 = c; c22 = d;
   endtask

   task automatic load_rand();
      load(EW'($urandom), EW'($urandom), EW'($urandom), EW'($urandom));
   endtask

   // Check outputs against the model, then advance the model and the DUT one cycle.
   task automatic step(input string tag);
      bit beat, mpop, mwr;
      chk({tag, ":valid"}, 32'(out_valid), 32'(mcount != 0));
      chk({tag, ":count"}, 32'(count), 32'(mcount));
      chk({tag, ":afull"}, 32'(afull), 32'(mcount >= DEPTH - 1));
      chk({tag, ":ovf"}, 32'(ovf), 32'(movf));
      if (mcount != 0) begin
         if (q.size() == 0) begin
            chk({tag, ":sb_empty"}, 32'(out_valid), 32'd0);
         end else begin
            chk({tag, ":data"}, 32'(out_data), 32'(q[0].data));
            chk({tag, ":idx"}, 32'(out_idx), 32'(q[0].idx));
            chk({tag, ":last"}, 32'(out_last), 32'(q[0].idx == 2'd3));
         end
      end
      if (rst) begin
         mcount = 0;
         melem  = 0;
         movf   = 1'b0;
         q.delete();
      end else begin
         beat = (mcount != 0) && out_ready;
         mpop = beat && (melem == 3);
         mwr  = in_val && ((mcount < DEPTH) || mpop);
         if (beat && q.size() > 0) void'(q.pop_front());
         if (mwr) begin
            q.push_back('{idx: 2'd0, data: c11});
            q.push_back('{idx: 2'd1, data: c12});
            q.push_back('{idx: 2'd2, data: c21});
            q.push_back('{idx: 2'd3, data: c22});
         end
         if (in_val && !mwr) movf = 1'b1;
         if (beat) melem = (melem + 1) % 4;
         if (mwr && !mpop) mcount++;
         else if (mpop && !mwr) mcount--;
      end
      if (mcount > maxcount) maxcount = mcount;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_val = 1'b0;
      step("rst");
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_val = 1'b0; out_ready = 1'b0;
      c11 = '0; c12 = '0; c21 = '0; c22 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset:valid", 32'(out_valid), 32'd0);
      chk("reset:idx", 32'(out_idx), 32'd0);
      chk("reset:last", 32'(out_last), 32'd0);
      chk("reset:afull", 32'(afull), 32'd0);
      chk("reset:ovf", 32'(ovf), 32'd0);
      chk("reset:count", 32'(count), 32'd0);

      // Single matrix with full-scale c22 and ready held high.
      out_ready = 1'b1;
      load(9'd1, 9'd2, 9'd3, 9'd511);
      step("single");
      in_val = 1'b0;
      repeat (6) step("single");
      chk("single:drained", 32'(q.size()), 32'd0);

      // Stall: head must hold while ready is low.
      out_ready = 1'b0;
      load(9'd5, 9'd6, 9'd7, 9'd8);
      step("stall");
      in_val = 1'b0;
      repeat (5) step("stall");
      chk("stall:idx_held", 32'(out_idx), 32'd0);
      chk("stall:data_held", 32'(out_data), 32'd5);
      out_ready = 1'b1;
      repeat (5) step("stall_go");

      // Full FIFO with a pop and a write in the same cycle.
      do_reset();
      out_ready = 1'b0;
      repeat (DEPTH) begin
         load_rand();
         step("fill");
      end
      in_val = 1'b0;
      chk("fill:count", 32'(count), 32'(DEPTH));
      out_ready = 1'b1;
      repeat (3) step("fullpop_pre");
      chk("fullpop:idx", 32'(out_idx), 32'd3);
      load_rand();
      step("fullpop");
      in_val = 1'b0;
      chk("fullpop:count", 32'(count), 32'(DEPTH));
      chk("fullpop:ovf", 32'(ovf), 32'd0);
      repeat (20) step("fullpop_drain");
      chk("fullpop:drained", 32'(q.size()), 32'd0);

      // Overflow: fifth matrix dropped, ovf sticky.
      out_ready = 1'b0;
      repeat (DEPTH + 1) begin
         load_rand();
         step("ovf_fill");
      end
      in_val = 1'b0;
      step("ovf_hold");
      chk("ovf:flag", 32'(ovf), 32'd1);
      chk("ovf:count", 32'(count), 32'(DEPTH));
      out_ready = 1'b1;
      repeat (20) step("ovf_drain");
      chk("ovf:drained", 32'(q.size()), 32'd0);
      chk("ovf:sticky", 32'(ovf), 32'd1);

      // Back-to-back matrices every 4 cycles across pointer wrap.
      do_reset();
      maxcount = 0;
      out_ready = 1'b1;
      for (int m = 0; m < 10; m++) begin
         load_rand();
         step("b2b");
         in_val = 1'b0;
         repeat (3) step("b2b");
      end
      repeat (5) step("b2b_tail");
      chk("b2b:maxcount_le2", 32'(maxcount <= 2), 32'd1);
      chk("b2b:drained", 32'(q.size()), 32'd0);

      // Reset after the second beat of a matrix.
      load_rand();
      step("midrst");
      in_val = 1'b0;
      repeat (2) step("midrst");
      chk("midrst:idx_before", 32'(out_idx), 32'd2);
      do_reset();
      chk("midrst:valid", 32'(out_valid), 32'd0);
      chk("midrst:count", 32'(count), 32'd0);
      chk("midrst:ovf", 32'(ovf), 32'd0);
      load(9'd100, 9'd200, 9'd300, 9'd400);
      step("midrst_next");
      in_val = 1'b0;
      chk("midrst:next_idx", 32'(out_idx), 32'd0);
      repeat (5) step("midrst_next");
      chk("midrst:drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_result_drain.md
PE_RESULT_DRAIN -- requirements
Module: pe_result_drain

Interface
REQ-001 Parameter WIDTH, default 4, operand width; result element width is 2*WIDTH+1 (9 bits at default).
REQ-002 Parameter DEPTH, default 4, result FIFO depth in 2x2 result matrices; SHALL be a power of 2, minimum 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_val  input  1  one complete 2x2 result matrix presented this cycle; no backpressure upstream.
REQ-006 c11, c12, c21, c22  input  2*WIDTH+1 each  result matrix elements, sampled when in_val=1.
REQ-007 out_valid  output  1  serialized element available on out_data.
REQ-008 out_ready  input  1  downstream accepts the element when out_valid=1 and out_ready=1 (a "beat").
REQ-009 out_data  output  2*WIDTH+1  current element.
REQ-010 out_idx  output  2  element index: 0=c11, 1=c12, 2=c21, 3=c22.
REQ-011 out_last  output  1  high when out_idx=3, marks the final element of a matrix.
REQ-012 afull  output  1  FIFO holds DEPTH-1 or more matrices; upstream throttle hint.
REQ-013 ovf  output  1  sticky flag: a matrix was dropped.
REQ-014 count  output  $clog2(DEPTH)+1  number of matrices stored, including the one being serialized.

Function
REQ-015 Storage: DEPTH-entry circular FIFO; each entry holds {c22,c21,c12,c11}; write and read pointers wrap modulo DEPTH.
REQ-016 Write: on in_val=1, if count<DEPTH or a pop occurs the same cycle, the matrix is written at the write pointer and the pointer advances.
REQ-017 Drop: on in_val=1 with count=DEPTH and no pop in the same cycle, the matrix is discarded, FIFO contents are unchanged, and ovf is set on the next edge.
REQ-018 ovf, once set, SHALL stay at 1 until rst; further drops have no additional effect.
REQ-019 Serializer state: 2-bit element counter elem; states are EMPTY (count=0) and SEND (count>0).
REQ-020 out_valid SHALL equal (count!=0); out_data SHALL be element elem of the head entry; out_idx SHALL equal elem; out_last SHALL equal (elem==3).
REQ-021 On a beat with elem<3, elem increments by 1; head entry and count are unchanged.
REQ-022 On a beat with elem=3 (pop), elem returns to 0, the read pointer advances, and count decrements unless a write is accepted the same cycle.
REQ-023 If a write and a pop occur in the same cycle, count is unchanged.
REQ-024 out_data, out_idx and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Latency: a matrix written into an empty FIFO at edge N produces out_valid=1 with out_idx=0 in the cycle after edge N.
REQ-026 Throughput: one element per cycle with out_ready held high, so one matrix is drained every 4 cycles.
REQ-027 Elements SHALL be emitted bit-exact, with no sign extension or truncation.
REQ-028 afull SHALL equal (count >= DEPTH-1), driven combinationally from count.

Reset
REQ-029 While rst=1 at a clock edge: count=0, both pointers=0, elem=0, ovf=0.
REQ-030 The following hold in the cycle after reset: out_valid=0, out_idx=0, out_last=0, afull=0, ovf=0, count=0.
REQ-031 out_data is don't-care while out_valid=0.
REQ-032 Reset asserted mid-matrix discards all stored data and any partially sent matrix; in_val is ignored in any cycle where rst=1.

Verification
REQ-033 Single matrix, out_ready=1: c11=1, c12=2, c21=3, c22=511 -> four consecutive beats with out_data 1,2,3,511, out_idx 0..3, out_last=1 on the 4th beat only, then out_valid=0.
REQ-034 Stall: send one matrix, hold out_ready=0 for 5 cycles after out_valid rises -> out_data=c11 and out_idx=0 stay stable; release out_ready -> normal 4-beat sequence.
REQ-035 Overflow: out_ready=0, apply in_val on 5 consecutive cycles (DEPTH=4) -> count=4, afull=1 from count=3, ovf=1 after the 5th in_val; draining yields only the first 4 matrices in order.
REQ-036 Full with simultaneous pop: FIFO full, elem=3, out_ready=1, in_val=1 in the same cycle -> matrix accepted, count stays 4, ovf stays 0.
REQ-037 Back-to-back input every 4 cycles with out_ready=1 -> count never exceeds 2, continuous out_valid, pointer wrap exercised over 10 matrices with correct ordering.
REQ-038 Reset mid-stream: assert rst after the 2nd beat of a matrix -> the next cycle shows out_valid=0, count=0, ovf=0; the next matrix starts at out_idx=0.
